// File: rtl/jtag_host_shifter_pkg.sv
// Shared definitions for the byte-wide JTAG host shifter.
//   JTAG_BYTE_W  : width of one command/response byte
//   BIT_CNT_LAST : bit index of the final bit in a byte
//   state_e      : shifter FSM states
package jtag_host_pkg;

  localparam int unsigned JTAG_BYTE_W  = 8;
  localparam logic [2:0]  BIT_CNT_LAST = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StTckLo,
    StTckHi,
    StResp
  } state_e;

endpackage

// File: rtl/jtag_host_shifter_if.sv
// Command/response handshake bundle between debug firmware logic and the shifter.
//   cmd_valid/cmd_ready/cmd_data/cmd_tms : command byte in, optional TMS on last bit
//   rsp_valid/rsp_ready/rsp_data         : captured TDO byte out
// Modports: master = command producer / response consumer, slave = shifter engine.
interface jtag_host_shifter_if;
  import jtag_host_pkg::*;

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [JTAG_BYTE_W-1:0] cmd_data;
  logic                   cmd_tms;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [JTAG_BYTE_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_data, cmd_tms, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_tms, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/jtag_host_shifter.sv
// Byte-wide JTAG host engine. Accepts a command byte, shifts it LSB-first onto tdi
// with a divided tck, captures 8 tdo bits and returns them as a response byte.
//   clk, rst : system clock, asynchronous active-high reset
//   host     : command/response handshake (slave side)
//   tck      : JTAG clock, registered, idle low; CLK_DIV clk cycles per half-period
//   tms      : high during the last bit only when the command requested it
//   tdi      : JTAG data to target, registered
//   tdo      : JTAG data from target, treated as synchronous to clk
module jtag_host_shifter
  import jtag_host_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  jtag_host_shifter_if.slave host,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int unsigned       PhaseW    = $clog2(CLK_DIV) + 1;
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(CLK_DIV - 1);

  state_e                 state_q, state_d;
  logic [PhaseW-1:0]      phase_q, phase_d;
  logic [2:0]             bit_q, bit_d;
  logic [JTAG_BYTE_W-1:0] tx_q, tx_d;
  logic [JTAG_BYTE_W-1:0] rx_q, rx_d;
  logic                   tms_lat_q, tms_lat_d;
  logic                   tck_q, tck_d;
  logic                   tms_q, tms_d;
  logic                   tdi_q, tdi_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   phase_end;

  assign phase_end = (phase_q == PhaseLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      tms_lat_q   <= 1'b0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b0;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      tms_lat_q   <= tms_lat_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    tms_lat_d   = tms_lat_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;

    unique case (state_q)
      StIdle: begin
        // Ready comes up one edge after reset release or response handshake.
        cmd_ready_d = 1'b1;
        if (host.cmd_valid && cmd_ready_q) begin
          tx_d        = host.cmd_data;
          tms_lat_d   = host.cmd_tms;
          bit_d       = '0;
          phase_d     = '0;
          // Present bit 0 now so it is stable for the whole low phase.
          tdi_d       = host.cmd_data[0];
          tms_d       = 1'b0;
          cmd_ready_d = 1'b0;
          state_d     = StTckLo;
        end
      end

      StTckLo: begin
        if (phase_end) begin
          // Sample before the rising edge: tdo still shows the pre-shift target bit.
          rx_d    = {tdo, rx_q[JTAG_BYTE_W-1:1]};
          tck_d   = 1'b1;
          phase_d = '0;
          state_d = StTckHi;
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end

      StTckHi: begin
        if (phase_end) begin
          tck_d   = 1'b0;
          tx_d    = tx_q >> 1;
          phase_d = '0;
          if (bit_q == BIT_CNT_LAST) begin
            tdi_d   = 1'b0;
            tms_d   = 1'b0;
            state_d = StResp;
          end else begin
            bit_d   = bit_q + 3'd1;
            // Next bit's data and TMS change together with the falling edge.
            tdi_d   = tx_q[1];
            tms_d   = tms_lat_q && (bit_q == BIT_CNT_LAST - 3'd1);
            state_d = StTckLo;
          end
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end

      StResp: begin
        // First RESP cycle raises valid; handshake is only taken once valid is visible.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (host.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign host.cmd_ready = cmd_ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rx_q;
  assign tck            = tck_q;
  assign tms            = tms_q;
  assign tdi            = tdi_q;

endmodule

// File: doc/jtag_host_shifter.md
# jtag_host_shifter

Byte-wide JTAG host engine sitting directly upstream of `jtag_debug`. It accepts an 8-bit command over a valid/ready handshake and serialises it LSB-first onto `tdi` with a divided `tck`. It captures the 8 `tdo` bits shifted out of the target and returns them as a response byte over a second valid/ready handshake. It lets SoC-side debug firmware drive the debug TAP, including halting the CPU by shifting in 0xFF, without bit-banging.

## Interface
- `CLK_DIV`, default 2: `clk` cycles per `tck` half-period; legal range ≥1.
- `clk` input 1: system clock; all logic sits on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `cmd_valid` input 1: command byte is available.
- `cmd_ready` output 1: engine is idle and will accept a command.
- `cmd_data` input 8: byte to shift into the target, LSB first.
- `cmd_tms` input 1: when 1, `tms` is driven high for the last bit only.
- `rsp_valid` output 1: captured byte is available.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_data` output 8: captured `tdo` byte (first captured bit lands in bit 0).
- `tck` output 1: JTAG clock, registered, idle low.
- `tms` output 1: JTAG mode select, registered.
- `tdi` output 1: JTAG data to target, registered.
- `tdo` input 1: JTAG data from target.

## Operation
- FSM states: IDLE, TCK_LO, TCK_HI, RESP.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`: latch `cmd_data` into the TX shift register and latch `cmd_tms`.
  - Clear the bit counter (3 bits) and the phase counter, then go to TCK_LO.
  - `cmd_valid` while not in IDLE is ignored and never queued.
- **TCK_LO**
  - `tck`=0, `tdi`=tx[0], `tms`=(latched_tms && bit_cnt==7).
  - Hold for `CLK_DIV` cycles.
  - On the final cycle: sample `tdo` into the RX register (rx <= {tdo, rx[7:1]}), set `tck`=1, go to TCK_HI.
- **TCK_HI**
  - `tck`=1; `tdi` and `tms` stay stable. Hold for `CLK_DIV` cycles.
  - On the final cycle: shift tx right and set `tck`=0.
  - If bit_cnt==7, go to RESP with `tms`=0 and `tdi`=0; otherwise increment bit_cnt and go to TCK_LO.
- **RESP**
  - `rsp_valid`=1; `rsp_data`=rx, stable until the handshake completes.
  - On `rsp_valid`&&`rsp_ready`: go to IDLE.
- Bit-count wrap: the 3-bit counter terminates at 7 and never wraps into a 9th bit.
- `tdo` is sampled before the `tck` rising edge, so the host sees the target LSB that precedes that edge's shift.
- `tdo` is treated as synchronous to `clk`; `tck` is derived from `clk`, so no synchroniser is present.

## Timing
- Reset values:
  - `tck`, `tms`, `tdi`, `rsp_valid`, `cmd_ready` = 0.
  - `rsp_data` = 0x00.
  - State is IDLE.
- `cmd_ready` is a registered output and rises at the first `clk` edge after `rst` deasserts.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously). No response is produced and the partial byte is discarded.
- Bit period is 2·`CLK_DIV` `clk` cycles; a full byte takes 16·`CLK_DIV` cycles.
- Latency: with the accepting edge as cycle 0, `rsp_valid` rises at edge 16·`CLK_DIV`+1. With `CLK_DIV`=2 that is edge 33.
- `cmd_ready` drops at edge 1. It rises one edge after the response handshake.
- If `rsp_ready` is already high when `rsp_valid` rises, the handshake completes on that edge and `cmd_ready` is 1 on the next edge. There is no combinational ready-to-valid path.
- Exactly 8 `tck` rising edges occur per command. `tdi` and `tms` change only while `tck` is low, at least `CLK_DIV` cycles before each rising edge.

## Structure
- Package `jtag_host_pkg`:
  - FSM state enum (IDLE, TCK_LO, TCK_HI, RESP).
  - `JTAG_BYTE_W`=8.
  - `BIT_CNT_LAST`=3'd7.
- No sub-module: the single module holds the FSM, phase counter (width $clog2(`CLK_DIV`)+1), bit counter, and TX/RX registers.

## Test plan
- **Reset:** assert `rst` for 3 cycles → all outputs 0. `cmd_ready`=1 one edge after release.
- **Halt via bench target model:** bench uses an 8-bit shift register on `tck` with `tdo`=reg[0], preloaded 0x5A. Send 0xFF with `CLK_DIV`=2:
  - `rsp_data`=0x5A at edge 33.
  - Model now holds 0xFF, so its `halt_cpu` is 1.
  - A second command 0x3C returns 0xFF.
- **TMS:** `cmd_tms`=1, data 0x81 → `tms` high for exactly one `tck` rising edge (the 8th); `tms`=0 otherwise. With `cmd_tms`=0, `tms` is never high.
- **Back-pressure:** hold `rsp_ready`=0 for 10 cycles after `rsp_valid` →
  - `rsp_data` is stable and `cmd_ready`=0.
  - A `cmd_valid` pulse during this window is ignored.
  - `rsp_ready`=1 → `cmd_ready`=1 on the next edge.
- **Reset mid-shift:** assert `rst` after the 4th `tck` rising edge →
  - `tck`, `tms`, `tdi` = 0 with no clock edge needed.
  - No `rsp_valid`.
  - The next command, 0xA5 with `tdo` tied to 1, returns 0xFF after the full 16·`CLK_DIV`+1 latency.
- **`CLK_DIV`=1:** `tck` toggles every `clk` cycle and latency is 17 cycles. Back-to-back commands with `rsp_ready` held high give a 19-cycle accept-to-accept period.
